// File: rtl/syscall_unit.sv
// Syscall service unit: stalls the pipeline while printing an integer or character
// from the $v0/$a0 taps, or halting, and streams console bytes over valid/ready.
module syscall_unit #(
    parameter logic [31:0] PRINT_INT  = 32'd1,
    parameter logic [31:0] PRINT_CHAR = 32'd11,
    parameter logic [31:0] EXIT       = 32'd10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        syscallValid,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        busy,
    output logic        done,
    output logic        badCode,
    output logic        halted,
    output logic        charValid,
    output logic [7:0]  charData,
    input  logic        charReady
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_DIV,
        S_EMIT,
        S_CHAR,
        S_FIN,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  d_q, d_d;
    logic        started_q, started_d;
    logic [7:0]  char_q, char_d;
    logic        bad_q, bad_d;

    logic [31:0] pow_k;
    logic        xfer;

    function automatic logic [31:0] pow10(input logic [3:0] k);
        case (k)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            k_q       <= 4'd9;
            d_q       <= '0;
            started_q <= 1'b0;
            char_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            k_q       <= k_d;
            d_q       <= d_d;
            started_q <= started_d;
            char_q    <= char_d;
            bad_q     <= bad_d;
        end
    end

    // Outputs decode registered state only; charReady merely qualifies transitions.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        badCode   = (state_q == S_FIN) && bad_q;
        halted    = (state_q == S_HALT);
        charValid = 1'b0;
        charData  = 8'h00;
        case (state_q)
            S_SIGN: begin
                charValid = 1'b1;
                charData  = 8'h2D;
            end
            S_EMIT: begin
                charValid = 1'b1;
                charData  = 8'h30 + {4'h0, d_q};
            end
            S_CHAR: begin
                charValid = 1'b1;
                charData  = char_q;
            end
            default: ;
        endcase
    end

    assign xfer  = charValid && charReady;
    assign pow_k = pow10(k_q);

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        k_d       = k_q;
        d_d       = d_q;
        started_d = started_q;
        char_d    = char_q;
        bad_d     = bad_q;
        case (state_q)
            S_IDLE: begin
                if (syscallValid) begin
                    k_d       = 4'd9;
                    d_d       = '0;
                    started_d = 1'b0;
                    bad_d     = 1'b0;
                    if (v0 == PRINT_CHAR) begin
                        char_d  = a0[7:0];
                        state_d = S_CHAR;
                    end else if (v0 == PRINT_INT) begin
                        if (a0[31]) begin
                            mag_d   = 32'd0 - a0;
                            state_d = S_SIGN;
                        end else begin
                            mag_d   = a0;
                            state_d = S_DIV;
                        end
                    end else if (v0 == EXIT) begin
                        state_d = S_HALT;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_SIGN: begin
                if (xfer) state_d = S_DIV;
            end
            S_DIV: begin
                // Leading zeros are skipped until the first non-zero digit or the units place.
                if (mag_q >= pow_k) begin
                    mag_d = mag_q - pow_k;
                    d_d   = d_q + 4'd1;
                end else if ((d_q != 4'd0) || started_q || (k_q == 4'd0)) begin
                    state_d = S_EMIT;
                end else begin
                    k_d = k_q - 4'd1;
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    started_d = 1'b1;
                    if (k_q == 4'd0) begin
                        state_d = S_FIN;
                    end else begin
                        k_d     = k_q - 4'd1;
                        d_d     = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_CHAR: begin
                if (xfer) state_d = S_FIN;
            end
            S_FIN: begin
                bad_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: stimulus pushes expected console bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_syscall_unit;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        syscallValid = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        busy, done, badCode, halted, charValid;
    logic [7:0]  charData;
    logic        charReady;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int bad_cnt = 0;
    int byte_cnt = 0;
    int busy_cnt = 0;
    logic toggle_mode = 1'b0;
    logic [7:0] exp_q[$];

    syscall_unit #(.PRINT_INT(32'd1), .PRINT_CHAR(32'd11), .EXIT(32'd10)) dut (
        .clock(clock), .resetn(resetn), .syscallValid(syscallValid),
        .v0(v0), .a0(a0), .busy(busy), .done(done), .badCode(badCode),
        .halted(halted), .charValid(charValid), .charData(charData),
        .charReady(charReady)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        charReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (toggle_mode) charReady = ~charReady;
            else charReady = 1'b1;
        end
    end

    // Monitor: a byte counts when valid&ready is seen half a cycle before the edge.
    initial begin
        logic       held_valid;
        logic [7:0] held_data;
        held_valid = 1'b0;
        held_data  = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    check("hold_valid", {31'd0, charValid}, 32'd1);
                    check("hold_data", {24'd0, charData}, {24'd0, held_data});
                end
                held_valid = charValid && !charReady;
                held_data  = charData;
                if (charValid && charReady) begin
                    byte_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", charData);
                    end else begin
                        check("byte", {24'd0, charData}, {24'd0, exp_q.pop_front()});
                    end
                end
                if (busy) busy_cnt++;
                if (done) done_cnt++;
                if (badCode) bad_cnt++;
                if (badCode && !done) check("bad_without_done", {31'd0, done}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        @(posedge clock);
        #1;
        syscallValid = 1'b1;
        v0 = code;
        a0 = arg;
        @(posedge clock);
        #1;
        syscallValid = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_done(input string name, input int start, input int budget);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check({name, "_done"}, done_cnt - start, 32'd1);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic print_int(input string name, input logic [31:0] val, input string txt);
        int d0, b0;
        d0 = done_cnt;
        b0 = byte_cnt;
        push_str(txt);
        issue(32'd1, val);
        wait_done(name, d0, 400);
        check({name, "_bytes"}, byte_cnt - b0, txt.len());
    endtask

    initial begin
        int d0, b0, bz0, bd0, n;
        logic ok;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_bad", {31'd0, badCode}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_valid", {31'd0, charValid}, 0);
        check("rst_data", {24'd0, charData}, 0);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // PRINT_CHAR with ready high
        d0 = done_cnt; bz0 = busy_cnt; b0 = byte_cnt;
        exp_q.push_back(8'h41);
        issue(32'd11, 32'h41);
        check("char_valid", {31'd0, charValid}, 1);
        check("char_data", {24'd0, charData}, 32'h41);
        wait_done("char", d0, 20);
        check("char_busy_cycles", busy_cnt - bz0, 2);
        check("char_bytes", byte_cnt - b0, 1);

        // PRINT_INT with toggling backpressure
        toggle_mode = 1'b1;
        print_int("int305", 32'd305, "305");
        toggle_mode = 1'b0;

        print_int("int0", 32'd0, "0");
        print_int("intm1", 32'hFFFF_FFFF, "-1");
        print_int("intmin", 32'h8000_0000, "-2147483648");

        // Extra request while busy must be ignored
        d0 = done_cnt; b0 = byte_cnt;
        push_str("2147483647");
        issue(32'd1, 32'h7FFF_FFFF);
        repeat (5) @(posedge clock);
        issue(32'd11, 32'h21);
        wait_done("intmax", d0, 400);
        check("intmax_bytes", byte_cnt - b0, 10);

        // Unsupported code
        d0 = done_cnt; b0 = byte_cnt; bd0 = bad_cnt;
        issue(32'd5, 32'h0);
        check("bad_pulse", {31'd0, badCode}, 1);
        check("bad_done_pulse", {31'd0, done}, 1);
        check("bad_no_valid", {31'd0, charValid}, 0);
        wait_done("bad", d0, 20);
        check("bad_count", bad_cnt - bd0, 1);
        check("bad_bytes", byte_cnt - b0, 0);

        // EXIT, then an ignored request
        d0 = done_cnt; b0 = byte_cnt;
        issue(32'd10, 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!(halted && busy)) ok = 1'b0;
        end
        check("halt_persist", {31'd0, ok}, 1);
        issue(32'd11, 32'h33);
        repeat (20) @(negedge clock);
        check("halt_no_done", done_cnt - d0, 0);
        check("halt_no_bytes", byte_cnt - b0, 0);
        check("halt_still", {31'd0, halted}, 1);

        @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("halt_reset_clears", {31'd0, halted}, 0);
        check("halt_reset_busy", {31'd0, busy}, 0);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Reset after the third byte of a long number
        b0 = byte_cnt;
        push_str("123");
        issue(32'd1, 32'd123456789);
        n = 0;
        while (byte_cnt - b0 < 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("mid_three_bytes", byte_cnt - b0, 3);
        @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 0);
        check("mid_done", {31'd0, done}, 0);
        check("mid_bad", {31'd0, badCode}, 0);
        check("mid_halted", {31'd0, halted}, 0);
        check("mid_valid", {31'd0, charValid}, 0);
        check("mid_data", {24'd0, charData}, 0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        d0 = done_cnt; b0 = byte_cnt;
        exp_q.push_back(8'h5A);
        issue(32'd11, 32'h5A);
        wait_done("after_reset", d0, 20);
        check("after_reset_bytes", byte_cnt - b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Consumer of the register file's `v0`/`a0` taps. On a `syscall` it stalls the pipeline and services the request held in `$v0`/`$a0`:
- print a signed decimal integer;
- print a character;
- halt.

Console output leaves as a byte stream with a valid/ready handshake. The unit sits beside the register file and drives the pipeline stall and the simulation console model.

## Interface
Parameters:
- `PRINT_INT`, 1, `$v0` code for print signed integer
- `PRINT_CHAR`, 11, `$v0` code for print character
- `EXIT`, 10, `$v0` code for halt

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `syscallValid`  in  1  one-cycle pulse from decode: syscall present
- `v0`  in  32  service code (register file `$v0` tap)
- `a0`  in  32  argument (register file `$a0` tap)
- `busy`  out  1  stall request; pipeline holds while high
- `done`  out  1  one-cycle pulse: service finished
- `badCode`  out  1  one-cycle pulse: unsupported `$v0`
- `halted`  out  1  sticky after `EXIT`
- `charValid`  out  1  output byte valid
- `charData`  out  8  ASCII byte
- `charReady`  in  1  console accepts byte

## Operation
- States:
  - IDLE: waits for a request.
  - SIGN: emits '-'.
  - DIV: performs one subtraction step per cycle.
  - EMIT: emits a digit.
  - CHAR: emits a character.
  - FIN: one-cycle completion.
  - HALT: terminal until reset.
- Accept: on a rising edge with state IDLE and `syscallValid`=1, latch `v0`/`a0`. `syscallValid` is ignored in every other state.
- PRINT_CHAR: go to CHAR and present `charData`=`a0[7:0]`. On transfer, go to FIN.
- PRINT_INT:
  - If `a0[31]`=1, go to SIGN and emit 0x2D. The magnitude is `-a0`, taken modulo 2^32 as unsigned, so 0x80000000 gives 2147483648.
  - Otherwise go straight to DIV with magnitude = `a0`.
  - Digit loop: index k runs 9 down to 0 over constants 10^k; digit counter d starts at 0.
  - DIV, each cycle: if mag ≥ 10^k, then mag -= 10^k and d++.
  - DIV, otherwise: if d≠0, or a digit was already emitted, or k=0, go to EMIT. Else set k--, keep d=0 and stay in DIV (leading-zero suppression).
  - EMIT: `charData` = 0x30+d. On transfer, set the started flag. Then if k=0 go to FIN; else k--, d=0, back to DIV.
  - Zero prints exactly "0".
- EXIT: go to HALT. `halted`=1 and `busy`=1 permanently. No `done` is issued.
- Any other code: go to FIN with `badCode`=1 for that cycle. No bytes are emitted.
- FIN: `done`=1 for one cycle, then IDLE.
- Handshake: a byte transfers on a rising edge with `charValid`=1 and `charReady`=1. Once `charValid` rises, `charData` holds stable and `charValid` stays high until the transfer. `charValid` is high only in SIGN, EMIT and CHAR.
- Arithmetic: mag is a 32-bit unsigned register and d is 4 bits. d never exceeds 9 because mag < 10^(k+1) holds on entry to each k.

## Timing
- Reset values: `busy`=0, `done`=0, `badCode`=0, `halted`=0, `charValid`=0, `charData`=0x00; state IDLE, k=9.
- Reset mid-operation: outputs drop immediately (asynchronous). A partial number is abandoned and never resumed. Reset also clears HALT.
- Outputs are registered (decoded from state only). None depends combinationally on `syscallValid` or `charReady`.
- `busy`=1 in every state except IDLE. The requester stalls from its pulse cycle through the `done` cycle.
- PRINT_CHAR with `charReady` held high:
  - accept at edge E0;
  - `charValid` high in cycle E0→E1, transfer at E1;
  - FIN/`done` in cycle E1→E2;
  - IDLE after E2.
- Unsupported code: accept at E0; `badCode`=`done`=1 in cycle E0→E1.
- PRINT_INT latency, with ready held high: (optional sign cycle) + (one DIV cycle per subtraction and per skipped or terminating k) + (one EMIT per digit) + 1 FIN. Worst case is under 120 cycles.
- A `syscallValid` pulse that coincides with FIN or HALT is dropped.

## Test plan
- PRINT_CHAR: `v0`=11, `a0`=0x00000041, `charReady`=1 → single byte 0x41, `busy` high for exactly 2 cycles, one `done` pulse.
- PRINT_INT positive with backpressure: `a0`=305, `charReady` toggling 1/0 every cycle → bytes "305" (0x33 0x30 0x35). `charData` stays stable while `charValid`=1 and `charReady`=0. Exactly one `done`.
- PRINT_INT edge values:
  - `a0`=0 → "0";
  - `a0`=0xFFFFFFFF → "-1";
  - `a0`=0x80000000 → "-2147483648";
  - `a0`=0x7FFFFFFF → "2147483647".
- EXIT then ignored request: `v0`=10 → `halted`=1 and `busy`=1 persist for 50 cycles. A later `syscallValid` produces no byte and no `done`.
- Unsupported code: `v0`=5 → `badCode` and `done` pulse together one cycle after accept; no `charValid`. A `syscallValid` pulse while busy printing is ignored, checked by byte count.
- Reset mid-print: `a0`=123456789, drive `resetn` low after the third byte → all outputs 0 at once. After release, `v0`=11, `a0`=0x5A emits 0x5A only.
